// File: rtl/spi_shift_engine.sv
// spi_shift_engine
//   SPI serialiser/deserialiser with a runtime word length, selectable bit
//   order and separate sample/shift strobes. The strobes come from the SCLK
//   generator, so every CPHA mode is covered by how the strobes are placed.
//   Each accepted load shifts exactly wordSize+1 bits and then pulses done.
//
// Ports
//   clock, reset    : system clock, synchronous active-high reset
//   enable          : clock enable; low freezes all state and masks done
//   wordSize        : word length minus one, latched when a load is accepted
//   lsbFirst        : 1 = LSB first, latched when a load is accepted
//   load, txData    : start request and transmit word (accepted only in IDLE)
//   sampleStrobe    : capture serialIn in this cycle
//   shiftStrobe     : advance one bit in this cycle
//   serialIn        : MISO
//   serialOut       : MOSI, taken directly from the shift register
//   busy            : transfer in progress
//   done            : one-cycle pulse at the end of a word
//   rxData          : last received word, right-aligned, zero above wordSize
module spi_shift_engine #(
  parameter int MAX_WORD_SIZE = 32,
  localparam int CW = $clog2(MAX_WORD_SIZE)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [CW-1:0]            wordSize,
  input  logic                     lsbFirst,
  input  logic                     load,
  input  logic [MAX_WORD_SIZE-1:0] txData,
  input  logic                     sampleStrobe,
  input  logic                     shiftStrobe,
  input  logic                     serialIn,
  output logic                     serialOut,
  output logic                     busy,
  output logic                     done,
  output logic [MAX_WORD_SIZE-1:0] rxData
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                   state_reg;
  logic [MAX_WORD_SIZE-1:0] shift_reg;
  logic [MAX_WORD_SIZE-1:0] rx_reg;
  logic [CW-1:0]            ws_reg;
  logic [CW-1:0]            cnt_reg;
  logic                     lf_reg;
  logic                     sbit_reg;
  logic                     busy_reg;
  logic                     done_reg;

  logic [MAX_WORD_SIZE-1:0] mask_ws;    // bits [ws_reg:0] set
  logic [MAX_WORD_SIZE-1:0] mask_load;  // bits [wordSize:0] set
  logic [MAX_WORD_SIZE-1:0] top_bit;    // only bit ws_reg set
  logic [MAX_WORD_SIZE-1:0] shift_next;
  logic                     in_bit;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_WORD_SIZE; gi++) begin : g_mask
      assign mask_ws[gi]   = (CW'(gi) <= ws_reg);
      assign mask_load[gi] = (CW'(gi) <= wordSize);
      assign top_bit[gi]   = (CW'(gi) == ws_reg);
    end
  endgenerate

  always_comb begin
    // Same-cycle sample and shift takes serialIn directly, so back-to-back
    // strobes need no separate sample cycle.
    in_bit     = sampleStrobe ? serialIn : sbit_reg;
    shift_next = '0;
    if (lf_reg) begin
      // Bits above ws are always zero, so bit ws is free after the right shift.
      shift_next = (shift_reg >> 1) | (in_bit ? top_bit : '0);
    end else begin
      shift_next = ((shift_reg << 1) | {{(MAX_WORD_SIZE-1){1'b0}}, in_bit}) & mask_ws;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      rx_reg    <= '0;
      ws_reg    <= '0;
      cnt_reg   <= '0;
      lf_reg    <= 1'b0;
      sbit_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (!enable) begin
      // Cleared so a pulse cannot reappear when enable returns.
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            shift_reg <= txData & mask_load;
            ws_reg    <= wordSize;
            lf_reg    <= lsbFirst;
            cnt_reg   <= wordSize;
            sbit_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (sampleStrobe) begin
            sbit_reg <= serialIn;
          end
          if (shiftStrobe) begin
            shift_reg <= shift_next;
            if (cnt_reg == '0) begin
              rx_reg    <= shift_next;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              cnt_reg <= cnt_reg - CW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign serialOut = lf_reg ? shift_reg[0] : shift_reg[ws_reg];
  assign busy      = busy_reg;
  assign done      = done_reg & enable;
  assign rxData    = rx_reg;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine; prints one line per word transfer.
module tb_spi_shift_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [4:0]  wordSize;
  logic        lsbFirst;
  logic        load;
  logic [31:0] txData;
  logic        sampleStrobe;
  logic        shiftStrobe;
  logic        serialIn;
  logic        serialOut;
  logic        busy;
  logic        done;
  logic [31:0] rxData;

  int checks = 0;
  int errors = 0;

  spi_shift_engine #(.MAX_WORD_SIZE(32)) dut (
    .clock(clock), .reset(reset), .enable(enable), .wordSize(wordSize),
    .lsbFirst(lsbFirst), .load(load), .txData(txData),
    .sampleStrobe(sampleStrobe), .shiftStrobe(shiftStrobe),
    .serialIn(serialIn), .serialOut(serialOut), .busy(busy), .done(done),
    .rxData(rxData)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive one complete word and check serialOut per bit, done/busy and rxData.
  // disturb: at bit 3, hold enable low for 3 cycles with every input active,
  // then keep load/config changes applied while the bit is shifted.
  task automatic run_word(input logic [31:0] tx, input logic [4:0] ws,
                          input logic lf, input logic [31:0] rxw,
                          input logic bypass, input logic disturb,
                          input string name);
    logic [31:0] mask;
    logic [31:0] exp_rx;
    int          idx;
    mask   = 32'((64'd1 << (ws + 1)) - 64'd1);
    exp_rx = rxw & mask;
    wordSize = ws; lsbFirst = lf; txData = tx; load = 1'b1;
    step();
    load = 1'b0; txData = 32'h0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s start busy/done got %b/%b exp 1/0", name, busy, done);
    end
    for (int k = 0; k <= int'(ws); k++) begin
      idx = lf ? k : int'(ws) - k;
      checks++;
      if (serialOut !== tx[idx]) begin
        errors++;
        $display("FAIL %s serialOut bit %0d got %b exp %b", name, k, serialOut, tx[idx]);
      end
      if (disturb && k == 3) begin
        enable = 1'b0; load = 1'b1; txData = 32'h0; wordSize = 5'd0;
        lsbFirst = ~lf; sampleStrobe = 1'b1; shiftStrobe = 1'b1;
        serialIn = ~rxw[idx];
        for (int c = 0; c < 3; c++) begin
          step();
          checks++;
          if (serialOut !== tx[idx] || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s frozen cycle %0d out/busy/done got %b/%b/%b exp %b/1/0",
                     name, c, serialOut, busy, done, tx[idx]);
          end
        end
        enable = 1'b1; sampleStrobe = 1'b0; shiftStrobe = 1'b0;
      end
      serialIn = rxw[idx];
      if (bypass) begin
        sampleStrobe = 1'b1; shiftStrobe = 1'b1;
        step();
      end else begin
        sampleStrobe = 1'b1;
        step();
        sampleStrobe = 1'b0; shiftStrobe = 1'b1;
        serialIn = ~rxw[idx];  // the stored sample must be used, not serialIn
        step();
      end
      sampleStrobe = 1'b0; shiftStrobe = 1'b0;
      load = 1'b0; wordSize = ws; lsbFirst = lf;
      if (k < int'(ws)) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s mid bit %0d busy/done got %b/%b exp 1/0", name, k, busy, done);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rxData !== exp_rx) begin
      errors++;
      $display("FAIL %s end done/busy/rx got %b/%b/%h exp 1/0/%h",
               name, done, busy, rxData, exp_rx);
    end
    $display("word %s tx=%h ws=%0d lf=%0d rx=%h exp=%h", name, tx, ws, lf, rxData, exp_rx);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; wordSize = 5'd0; lsbFirst = 1'b0; load = 1'b0;
    txData = 32'h0; sampleStrobe = 1'b0; shiftStrobe = 1'b0; serialIn = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rxData !== 32'h0 || serialOut !== 1'b0) begin
      errors++;
      $display("FAIL reset busy/done/rx/out got %b/%b/%h/%b exp 0/0/0/0",
               busy, done, rxData, serialOut);
    end
    // Strobes in IDLE must not start anything.
    sampleStrobe = 1'b1; shiftStrobe = 1'b1; serialIn = 1'b1;
    step();
    sampleStrobe = 1'b0; shiftStrobe = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rxData !== 32'h0) begin
      errors++;
      $display("FAIL idle_strobes busy/done/rx got %b/%b/%h exp 0/0/0", busy, done, rxData);
    end
    $display("reset checked");
  endtask

  task automatic test_msb_first();
    run_word(32'hA5, 5'd7, 1'b0, 32'h3C, 1'b0, 1'b0, "msb_first");
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL msb_first done_width got %b exp 0", done);
    end
  endtask

  task automatic test_lsb_first();
    run_word(32'hA5, 5'd7, 1'b1, 32'h3C, 1'b0, 1'b0, "lsb_first");
    step();
  endtask

  task automatic test_single_bit();
    run_word(32'hFFFFFFFF, 5'd0, 1'b0, 32'h1, 1'b0, 1'b0, "single_bit");
    step();
  endtask

  task automatic test_bypass_full();
    run_word(32'h12345678, 5'd31, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, "bypass_full");
    step();
  endtask

  task automatic test_disturb();
    run_word(32'hC3, 5'd7, 1'b0, 32'h96, 1'b0, 1'b1, "disturb");
    step();
  endtask

  task automatic test_mid_reset();
    wordSize = 5'd7; lsbFirst = 1'b0; txData = 32'hA5; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      serialIn = 1'b1; sampleStrobe = 1'b1;
      step();
      sampleStrobe = 1'b0; shiftStrobe = 1'b1;
      step();
      shiftStrobe = 1'b0;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rxData !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset busy/done/rx got %b/%b/%h exp 0/0/0", busy, done, rxData);
    end
    // Further strobes after the abort must not finish the word.
    for (int k = 0; k < 4; k++) begin
      sampleStrobe = 1'b1; shiftStrobe = 1'b1;
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_after %0d done/busy got %b/%b exp 0/0", k, done, busy);
      end
    end
    sampleStrobe = 1'b0; shiftStrobe = 1'b0;
    $display("mid-transfer reset checked");
    run_word(32'h5A, 5'd7, 1'b1, 32'h81, 1'b0, 1'b0, "after_reset");
    step();
  endtask

  task automatic test_back_to_back();
    run_word(32'hBEEF, 5'd15, 1'b1, 32'h1234, 1'b1, 1'b0, "b2b_first");
    // Next load is presented in the done cycle itself.
    run_word(32'h13, 5'd4, 1'b0, 32'h0B, 1'b0, 1'b0, "b2b_second");
    step();
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_single_bit();
    test_bypass_full();
    test_disturb();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
